// File: rtl/ycr_arb_pkg.sv
// Shared arbiter/bus-mux definitions: grant encodings, mux FSM states and the
// latched slave command.
package ycr_arb_pkg;

   localparam logic [1:0] GRANT0 = 2'b00;
   localparam logic [1:0] GRANT1 = 2'b01;
   localparam logic [1:0] GRANTX = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2,
      ST_DONE  = 2'd3
   } mux_state_e;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
   } bus_cmd_t;

endpackage

// File: rtl/ycr_tmo_cnt.sv
// Saturating ISSUE-phase timeout counter; expired flags the last allowed cycle.
module ycr_tmo_cnt #(
   parameter int unsigned TMO_CYC = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned     W    = $clog2(TMO_CYC + 1);
   localparam logic [W-1:0]    LAST = W'(TMO_CYC - 1);
   localparam logic [W-1:0]    SAT  = W'(TMO_CYC);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en && (cnt != SAT))
         cnt <= cnt + W'(1);
   end

   assign expired = (cnt == LAST);

endmodule

// File: rtl/ycr_bus_mux2.sv
// Two-master to one-slave bus mux driven by an external arbiter grant, with a
// slave timeout and registered outputs on every port.
module ycr_bus_mux2
   import ycr_arb_pkg::*;
#(
   parameter int unsigned TMO_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  gnt,
   output logic        arb_ack,

   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [1:0]  m0_size,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   output logic        m0_err,

   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [1:0]  m1_size,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic        m1_err,

   output logic        s_req,
   output logic        s_we,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [1:0]  s_size,
   input  logic        s_ack,
   input  logic [31:0] s_rdata,
   input  logic        s_err
);

   mux_state_e  state, state_nxt;
   bus_cmd_t    cmd, cmd_nxt;
   logic        owner, owner_nxt;

   logic        sel_valid, sel_port, sel_req;
   logic        tmo_clr, tmo_en, tmo_expired;

   logic        s_req_nxt, arb_ack_nxt;
   logic        rsp_ack_nxt, rsp_err_nxt;
   logic [31:0] rsp_rdata_nxt;

   assign sel_valid = (gnt == GRANT0) || (gnt == GRANT1);
   assign sel_port  = (gnt == GRANT1);
   assign sel_req   = sel_port ? m1_req : m0_req;

   assign tmo_clr = (state == ST_IDLE) && (state_nxt == ST_ISSUE);
   assign tmo_en  = (state == ST_ISSUE);

   ycr_tmo_cnt #(
      .TMO_CYC (TMO_CYC)
   ) u_tmo_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmo_clr),
      .en      (tmo_en),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cmd      <= '0;
         owner    <= 1'b0;
         s_req    <= 1'b0;
         arb_ack  <= 1'b0;
         m0_ack   <= 1'b0;
         m0_rdata <= '0;
         m0_err   <= 1'b0;
         m1_ack   <= 1'b0;
         m1_rdata <= '0;
         m1_err   <= 1'b0;
      end else begin
         state    <= state_nxt;
         cmd      <= cmd_nxt;
         owner    <= owner_nxt;
         s_req    <= s_req_nxt;
         arb_ack  <= arb_ack_nxt;
         m0_ack   <= rsp_ack_nxt && !owner;
         m0_rdata <= (rsp_ack_nxt && !owner) ? rsp_rdata_nxt : '0;
         m0_err   <= rsp_ack_nxt && !owner && rsp_err_nxt;
         m1_ack   <= rsp_ack_nxt && owner;
         m1_rdata <= (rsp_ack_nxt && owner) ? rsp_rdata_nxt : '0;
         m1_err   <= rsp_ack_nxt && owner && rsp_err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (sel_valid) state_nxt = sel_req ? ST_ISSUE : ST_DONE;
         ST_ISSUE: if (s_ack || tmo_expired) state_nxt = ST_RESP;
         ST_RESP:  state_nxt = ST_DONE;
         ST_DONE:  if (gnt == GRANTX) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Computes the next values of the output registers; s_ack beats the timeout.
   always_comb begin
      cmd_nxt       = cmd;
      owner_nxt     = owner;
      s_req_nxt     = (state_nxt == ST_ISSUE);
      arb_ack_nxt   = 1'b0;
      rsp_ack_nxt   = 1'b0;
      rsp_err_nxt   = 1'b0;
      rsp_rdata_nxt = '0;
      unique case (state)
         ST_IDLE: begin
            if (sel_valid) begin
               if (sel_req) begin
                  owner_nxt = sel_port;
                  cmd_nxt   = sel_port ? '{m1_we, m1_addr, m1_wdata, m1_size}
                                       : '{m0_we, m0_addr, m0_wdata, m0_size};
               end else begin
                  arb_ack_nxt = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            if (s_ack) begin
               rsp_ack_nxt   = 1'b1;
               rsp_rdata_nxt = s_rdata;
               rsp_err_nxt   = s_err;
               arb_ack_nxt   = 1'b1;
            end else if (tmo_expired) begin
               rsp_ack_nxt   = 1'b1;
               rsp_err_nxt   = 1'b1;
               arb_ack_nxt   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign s_we    = cmd.we;
   assign s_addr  = cmd.addr;
   assign s_wdata = cmd.wdata;
   assign s_size  = cmd.size;

endmodule
